ex_mul_div_unit: RTL and testbench
==================================

Name: ex_mul_div_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the operands and ALU-op decode latched by the ID/EX pipeline register and produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU, plus MTHI/MTLO writes. It runs a multi-cycle shift-add or restoring-divide sequence. Busy feeds the hazard unit, which stalls IF/ID/EX while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; also the iteration count.
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  synchronous, active-low reset; one clock.
Start  input  1  launch operation; sampled only in IDLE.
Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
OperandA  input  DATA_WIDTH  rs value (multiplicand / dividend).
OperandB  input  DATA_WIDTH  rt value (multiplier / divisor).
Flush  input  1  cancel in-flight operation.
WriteHi  input  1  MTHI strobe.
WriteLo  input  1  MTLO strobe.
WriteData  input  DATA_WIDTH  MTHI/MTLO data.
Busy  output  1  operation in progress.
Done  output  1  one-cycle pulse, HI/LO just updated by an operation.
Hi  output  DATA_WIDTH  HI register.
Lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (Reset==0 at posedge): state IDLE; Hi=0, Lo=0, Busy=0, Done=0; counter and working registers 0. Reset overrides all other inputs, including mid-operation.
- FSM states: IDLE, RUN, FIX.
  - IDLE: Start=1 -> RUN. On entry, latch Op. For signed ops, latch |OperandA| and |OperandB| and the sign flags. Counter := 0.
  - RUN: one multiply or divide step per cycle. Counter increments. After DATA_WIDTH steps -> FIX.
  - FIX: apply sign correction, write Hi/Lo -> IDLE.
- Busy = (state != IDLE) and is registered. With Start in cycle 0: Busy is high in cycles 1..DATA_WIDTH+1, Hi/Lo are new in cycle DATA_WIDTH+2, and Done=1 in cycle DATA_WIDTH+2 only. At default width: Busy for 33 cycles, results in cycle 34.
- Multiply:
  - Unsigned shift-add over a 2*DATA_WIDTH product.
  - Result: Hi = product[63:32], Lo = product[31:0].
  - MULT: the product is negated if the operand signs differ.
- Divide:
  - Restoring division on magnitudes. Lo = quotient, Hi = remainder.
  - DIV: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
- Divide by zero, either signedness: Hi = OperandA unmodified, Lo = all ones. Done still pulses after full latency.
- Start while Busy: ignored. The hazard unit must hold it.
- Flush while Busy: next state IDLE, Busy=0, no Done, Hi/Lo unchanged. Flush in IDLE has no effect. Flush and Start in the same IDLE cycle: Start is not accepted.
- WriteHi/WriteLo:
  - In IDLE, write at the next edge. Both may write in the same cycle.
  - While Busy, they are ignored.
  - Same IDLE cycle as an accepted Start: the write takes effect, and the operation overwrites Hi/Lo at FIX.
- Hi/Lo change only at FIX, on an IDLE write, or at reset.

Decomposition:
- Shared package/header holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state encodings.
  - The ALU-instruction-to-Op mapping constants used by the EX decode.
- One sub-module is natural: mul_div_sign_fix, combinational negate/abs and final sign correction, reused for operand prep and FIX.

Test Plan:
- MULTU 0xFFFFFFFF x 0x2, Start cycle 0 -> Busy cycles 1-33; cycle 34 Done=1, Hi=0x00000001, Lo=0xFFFFFFFE.
- MULT 0xFFFFFFFD (-3) x 0x5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. DIV 0xFFFFFFF9 (-7) / 0x2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- Edge divides:
  - DIVU 0x64 / 0 -> Hi=0x64, Lo=0xFFFFFFFF after full latency.
  - DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start DIVU 100/7, Flush in cycle 10 -> Busy=0 in cycle 11, no Done, Hi/Lo keep prior values. New Start in cycle 11 completes normally (Lo=14, Hi=2).
- WriteHi=1, WriteData=0xAAAA5555 in IDLE -> Hi=0xAAAA5555 next cycle. Same write while Busy -> ignored. Start while Busy -> ignored, result is from the first operation.
- Reset=0 in cycle 15 of a MULT -> next cycle Busy=0, Done=0, Hi=Lo=0. Operation lost; the next Start works.

Source files
------------

// File: rtl/ex_mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation and
// FSM encodings plus the decode constants that map ALU funct codes onto Op.
package ex_mul_div_unit_pkg;

    // Operation select driven by the ID/EX register.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // R-type funct codes handled by this unit.
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // True for the four funct codes that launch an iterative operation.
    function automatic logic is_mul_div_funct(input logic [5:0] funct);
        return (funct[5:2] == FUNCT_MULT[5:2]);
    endfunction

    // The Op encoding was chosen to equal the low two funct bits, so the
    // EX decode only has to forward them.
    function automatic md_op_e funct_to_op(input logic [5:0] funct);
        return md_op_e'(funct[1:0]);
    endfunction

endpackage

// File: rtl/ex_mul_div_unit_sign_fix.sv
// Combinational sign handling shared by operand preparation (magnitudes and
// sign flags on Start) and the final correction applied in FIX.
module mul_div_sign_fix
    import ex_mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_mag,
    output logic [DATA_WIDTH-1:0] b_mag,
    output logic                  a_neg,
    output logic                  b_neg,
    input  logic                  is_div,
    input  logic                  div_zero,
    input  logic                  neg_a_q,
    input  logic                  neg_b_q,
    input  logic [DATA_WIDTH-1:0] raw_a,
    input  logic [DATA_WIDTH-1:0] res_hi,
    input  logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] fix_hi,
    output logic [DATA_WIDTH-1:0] fix_lo
);

    logic [2*DATA_WIDTH-1:0] product;
    logic [2*DATA_WIDTH-1:0] product_neg;

    // Operand magnitudes; unsigned ops never report a negative operand.
    always_comb begin
        a_neg = op_signed & a_in[DATA_WIDTH-1];
        b_neg = op_signed & b_in[DATA_WIDTH-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;
    end

    // Final HI/LO: divide-by-zero passthrough, signed quotient/remainder,
    // or a full-width negated product when the operand signs differ.
    always_comb begin
        product     = {res_hi, res_lo};
        product_neg = -product;
        fix_hi      = res_hi;
        fix_lo      = res_lo;
        if (is_div) begin
            if (div_zero) begin
                fix_hi = raw_a;
                fix_lo = '1;
            end else begin
                fix_lo = (neg_a_q ^ neg_b_q) ? -res_lo : res_lo;
                fix_hi = neg_a_q ? -res_hi : res_hi;
            end
        end else if (neg_a_q ^ neg_b_q) begin
            fix_hi = product_neg[2*DATA_WIDTH-1:DATA_WIDTH];
            fix_lo = product_neg[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ex_mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. One shift-add or
// restoring-divide step per cycle on operand magnitudes, sign fix in FIX,
// plus MTHI/MTLO writes while idle. Busy drives the hazard unit stall.
module ex_mul_div_unit
    import ex_mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    input  logic                  Flush,
    input  logic                  WriteHi,
    input  logic                  WriteLo,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    md_op_e                op_in;
    logic                  in_signed;
    logic                  in_div;

    md_state_e             state;
    md_state_e             state_next;
    logic                  busy_q;
    logic                  busy_next;
    logic                  done_q;
    logic                  done_next;
    logic                  load_ops;
    logic                  do_step;
    logic                  write_result;
    logic                  last_step;

    md_op_e                op_q;
    logic                  is_div_q;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] work_hi;
    logic [DATA_WIDTH-1:0] work_lo;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] raw_a;
    logic                  neg_a_q;
    logic                  neg_b_q;
    logic                  div_zero_q;

    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] fix_hi;
    logic [DATA_WIDTH-1:0] fix_lo;

    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH+1:0] div_diff;
    logic [DATA_WIDTH-1:0] step_hi;
    logic [DATA_WIDTH-1:0] step_lo;

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;

    assign op_in     = md_op_e'(Op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign last_step = (count == CNT_WIDTH'(DATA_WIDTH - 1));

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

    mul_div_sign_fix #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sign_fix (
        .op_signed (in_signed),
        .a_in      (OperandA),
        .b_in      (OperandB),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_div    (is_div_q),
        .div_zero  (div_zero_q),
        .neg_a_q   (neg_a_q),
        .neg_b_q   (neg_b_q),
        .raw_a     (raw_a),
        .res_hi    (work_hi),
        .res_lo    (work_lo),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    // State, Busy and Done registers; Busy mirrors the next state so it is
    // already high in the first RUN cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    // Next-state and control: Start only counts in IDLE without Flush,
    // Flush abandons RUN or FIX without touching HI/LO.
    always_comb begin
        state_next   = state;
        done_next    = 1'b0;
        load_ops     = 1'b0;
        do_step      = 1'b0;
        write_result = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    state_next = ST_RUN;
                    load_ops   = 1'b1;
                end
            end
            ST_RUN: begin
                if (Flush) begin
                    state_next = ST_IDLE;
                end else begin
                    do_step = 1'b1;
                    if (last_step) begin
                        state_next = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                if (!Flush) begin
                    write_result = 1'b1;
                    done_next    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // One iteration: multiply keeps the multiplier in work_lo and shifts the
    // partial product right; divide shifts the dividend out of work_lo into
    // the remainder in work_hi and shifts quotient bits in.
    always_comb begin
        add_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_b} : '0);
        div_shift = {work_hi, work_lo[DATA_WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand_b};
        step_hi   = add_sum[DATA_WIDTH:1];
        step_lo   = {add_sum[0], work_lo[DATA_WIDTH-1:1]};
        if (is_div_q) begin
            step_hi = div_diff[DATA_WIDTH+1] ? div_shift[DATA_WIDTH-1:0]
                                             : div_diff[DATA_WIDTH-1:0];
            step_lo = {work_lo[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH+1]};
        end
    end

    // Working registers: latch magnitudes and sign flags on Start, then
    // advance one step per RUN cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            op_q       <= OP_MULT;
            count      <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            operand_b  <= '0;
            raw_a      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (load_ops) begin
            op_q       <= op_in;
            count      <= '0;
            work_hi    <= '0;
            work_lo    <= in_div ? a_mag : b_mag;
            operand_b  <= in_div ? b_mag : a_mag;
            raw_a      <= OperandA;
            neg_a_q    <= a_neg;
            neg_b_q    <= b_neg;
            div_zero_q <= in_div && (OperandB == '0);
        end else if (do_step) begin
            count   <= count + CNT_WIDTH'(1);
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    // Architectural HI/LO: operation result in FIX, MTHI/MTLO only in IDLE.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (write_result) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (state == ST_IDLE) begin
            if (WriteHi) begin
                hi_q <= WriteData;
            end
            if (WriteLo) begin
                lo_q <= WriteData;
            end
        end
    end

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Self-checking bench for ex_mul_div_unit: expected HI/LO pairs are pushed
// to a scoreboard when an operation is launched and popped on Done.
module tb_ex_mul_div_unit;

    localparam int DW = 32;
    localparam int LATENCY = DW + 2;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [1:0]    Op;
    logic [DW-1:0] OperandA;
    logic [DW-1:0] OperandB;
    logic          Flush;
    logic          WriteHi;
    logic          WriteLo;
    logic [DW-1:0] WriteData;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] Hi;
    logic [DW-1:0] Lo;

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] sb_q[$];

    ex_mul_div_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Flush     (Flush),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference result {HI, LO} computed with 64-bit arithmetic.
    function automatic logic [2*DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sbv;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        res = '0;
        case (op)
            2'b00: res = sa * sbv;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Launch one operation in the current cycle and follow it to Done.
    // mode 1: Start/WriteHi/WriteLo pulses while busy; mode 2: WriteLo in
    // the Start cycle.
    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode, input string name);
        int cyc;
        logic [DW-1:0] hi_before;
        logic [DW-1:0] lo_before;
        logic [2*DW-1:0] exp_v;
        Start = 1'b1;
        Op = op;
        OperandA = a;
        OperandB = b;
        if (mode == 2) begin
            WriteLo = 1'b1;
            WriteData = 32'h0000DEAD;
        end
        sb_q.push_back(model(op, a, b));
        tick();
        Start = 1'b0;
        WriteLo = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        if (mode == 2) begin
            checks++;
            if (Lo !== 32'h0000DEAD) begin
                errors++;
                $display("[TB] FAIL %s start_write_lo: got %h expected %h", name, Lo, 32'h0000DEAD);
            end
        end
        hi_before = Hi;
        lo_before = Lo;
        cyc = 1;
        while (Done !== 1'b1 && cyc < LATENCY + 20) begin
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s busy_c%0d: got %b expected 1", name, cyc, Busy);
            end
            if (mode == 1 && cyc == 5) begin
                Start = 1'b1;
                Op = 2'b01;
                OperandA = 32'h1;
                OperandB = 32'h1;
                WriteHi = 1'b1;
                WriteLo = 1'b1;
                WriteData = 32'h12345678;
            end
            if (mode == 1 && cyc == 6) begin
                Start = 1'b0;
                WriteHi = 1'b0;
                WriteLo = 1'b0;
                checks++;
                if (Hi !== hi_before || Lo !== lo_before) begin
                    errors++;
                    $display("[TB] FAIL %s busy_write: got %h_%h expected %h_%h", name, Hi, Lo, hi_before, lo_before);
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s done_timeout: got no Done expected Done in cycle %0d", name, LATENCY);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            checks++;
            if (cyc != LATENCY) begin
                errors++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, LATENCY);
            end
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s busy_at_done: got %b expected 0", name, Busy);
            end
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s scoreboard_empty: got Done expected none", name);
            end else begin
                exp_v = sb_q.pop_front();
                checks++;
                if (Hi !== exp_v[2*DW-1:DW]) begin
                    errors++;
                    $display("[TB] FAIL %s hi: got %h expected %h", name, Hi, exp_v[2*DW-1:DW]);
                end
                checks++;
                if (Lo !== exp_v[DW-1:0]) begin
                    errors++;
                    $display("[TB] FAIL %s lo: got %h expected %h", name, Lo, exp_v[DW-1:0]);
                end
            end
        end
        tick();
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: got %b expected 0", name, Done);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got busy=%b done=%b expected 0 0", Busy, Done);
        end
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", Hi, Lo);
        end
    endtask

    task automatic test_multiply();
        run_op(2'b01, 32'hFFFFFFFF, 32'h2, 0, "multu_max");
        run_op(2'b00, 32'hFFFFFFFD, 32'h5, 0, "mult_neg");
        run_op(2'b00, 32'h80000000, 32'h80000000, 0, "mult_minmin");
        for (int i = 0; i < 3; i++) begin
            run_op(2'(i % 2), $urandom, $urandom, 0, "mul_rand");
        end
    endtask

    task automatic test_divide();
        run_op(2'b10, 32'hFFFFFFF9, 32'h2, 0, "div_neg");
        run_op(2'b11, 32'd100, 32'd7, 0, "divu_small");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 0, "div_negdivisor");
        for (int i = 0; i < 3; i++) begin
            run_op(2'(2 + (i % 2)), $urandom, $urandom_range(1, 1000), 0, "div_rand");
        end
    endtask

    task automatic test_div_edge();
        run_op(2'b11, 32'h64, 32'h0, 0, "divu_zero");
        run_op(2'b10, 32'hFFFFFFFB, 32'h0, 0, "div_zero_neg");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
    endtask

    task automatic test_flush();
        logic [DW-1:0] hi_prev;
        logic [DW-1:0] lo_prev;
        hi_prev = Hi;
        lo_prev = Lo;
        Start = 1'b1;
        Op = 2'b11;
        OperandA = 32'd100;
        OperandB = 32'd7;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ctrl: got busy=%b done=%b expected 0 0", Busy, Done);
        end
        checks++;
        if (Hi !== hi_prev || Lo !== lo_prev) begin
            errors++;
            $display("[TB] FAIL flush_hilo: got %h_%h expected %h_%h", Hi, Lo, hi_prev, lo_prev);
        end
        run_op(2'b11, 32'd100, 32'd7, 0, "after_flush");
        hi_prev = Hi;
        Start = 1'b1;
        Flush = 1'b1;
        Op = 2'b01;
        OperandA = 32'h3;
        OperandB = 32'h3;
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_start_idle: got busy=%b expected 0", Busy);
            end
            tick();
        end
        checks++;
        if (Hi !== hi_prev || Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle_hold: got hi=%h done=%b expected hi=%h done=0", Hi, Done, hi_prev);
        end
    endtask

    task automatic test_hilo_write();
        WriteHi = 1'b1;
        WriteData = 32'hAAAA5555;
        tick();
        WriteHi = 1'b0;
        checks++;
        if (Hi !== 32'hAAAA5555) begin
            errors++;
            $display("[TB] FAIL mthi: got %h expected %h", Hi, 32'hAAAA5555);
        end
        WriteHi = 1'b1;
        WriteLo = 1'b1;
        WriteData = 32'h0F0F1234;
        tick();
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        checks++;
        if (Hi !== 32'h0F0F1234 || Lo !== 32'h0F0F1234) begin
            errors++;
            $display("[TB] FAIL mthi_mtlo: got %h_%h expected %h_%h", Hi, Lo, 32'h0F0F1234, 32'h0F0F1234);
        end
        run_op(2'b11, 32'd1000, 32'd9, 1, "busy_ignore");
        run_op(2'b01, 32'd6, 32'd7, 2, "start_write");
    endtask

    task automatic test_reset_mid();
        Start = 1'b1;
        Op = 2'b00;
        OperandA = 32'hFFFFFFF0;
        OperandB = 32'h00000011;
        sb_q.push_back(model(2'b00, 32'hFFFFFFF0, 32'h00000011));
        tick();
        Start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        void'(sb_q.pop_front());
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_ctrl: got busy=%b done=%b expected 0 0", Busy, Done);
        end
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_hilo: got %h_%h expected 0_0", Hi, Lo);
        end
        run_op(2'b00, 32'hFFFFFFF0, 32'h00000011, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(2'b10, 32'h7FFFFFFF, 32'h00010000, 0, "b2b_div");
        run_op(2'b00, 32'h12345678, 32'hFEDCBA98, 0, "b2b_mult");
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "b2b_divu");
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Op = 2'b00;
        OperandA = '0;
        OperandB = '0;
        Flush = 1'b0;
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        WriteData = '0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_edge();
        test_flush();
        test_hilo_write();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
